// File: rtl/wires.sv
// Shared bus types for the core-side memory ports and the arbiter that merges them.
package wires;

    typedef struct packed {
        logic        mem_valid;
        logic        mem_instr;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
        logic [3:0]  mem_wstrb;
    } mem_in_type;

    typedef struct packed {
        logic        mem_ready;
        logic [31:0] mem_rdata;
    } mem_out_type;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_BUSY_I = 2'd1,
        ARB_BUSY_D = 2'd2
    } arb_state_t;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_t;

    // On a tie: round-robin gives the side not granted last, otherwise data wins.
    function automatic grant_t arb_pick(input logic   i_pend,
                                        input logic   d_pend,
                                        input grant_t last,
                                        input logic   rr);
        if (i_pend && d_pend) begin
            return (rr && (last == GRANT_D)) ? GRANT_I : GRANT_D;
        end else if (i_pend) begin
            return GRANT_I;
        end
        return GRANT_D;
    endfunction

endpackage

// File: rtl/mem_arbiter_slot.sv
// One-deep request buffer for a single requester; o_req.mem_valid reports "pending".
module mem_arbiter_slot
    import wires::*;
(
    input  logic       clock,
    input  logic       reset,
    input  mem_in_type i_req,
    input  logic       i_clear,
    output mem_in_type o_req
);

    logic        r_pending;
    logic        r_instr;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;
    logic        w_load;

    // A new pulse is taken when empty or when the held request completes this cycle.
    assign w_load = i_req.mem_valid && (!r_pending || i_clear);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pending <= 1'b0;
            r_instr   <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
        end else if (w_load) begin
            r_pending <= 1'b1;
            r_instr   <= i_req.mem_instr;
            r_addr    <= i_req.mem_addr;
            r_wdata   <= i_req.mem_wdata;
            r_wstrb   <= i_req.mem_wstrb;
        end else if (i_clear) begin
            r_pending <= 1'b0;
        end
    end

    assign o_req = '{mem_valid: r_pending,
                     mem_instr: r_instr,
                     mem_addr:  r_addr,
                     mem_wdata: r_wdata,
                     mem_wstrb: r_wstrb};

endmodule

// File: rtl/mem_arbiter.sv
// Merges instruction and data request ports onto one memory bus with a single
// outstanding transaction; responses are steered back to the granted side.
module mem_arbiter
    import wires::*;
#(
    parameter int round_robin = 1
)(
    input  logic        reset,
    input  logic        clock,
    input  logic        imemory_valid,
    input  logic        imemory_instr,
    input  logic [31:0] imemory_addr,
    input  logic [31:0] imemory_wdata,
    input  logic [3:0]  imemory_wstrb,
    output logic [31:0] imemory_rdata,
    output logic        imemory_ready,
    input  logic        dmemory_valid,
    input  logic        dmemory_instr,
    input  logic [31:0] dmemory_addr,
    input  logic [31:0] dmemory_wdata,
    input  logic [3:0]  dmemory_wstrb,
    output logic [31:0] dmemory_rdata,
    output logic        dmemory_ready,
    output logic        memory_valid,
    output logic        memory_instr,
    output logic [31:0] memory_addr,
    output logic [31:0] memory_wdata,
    output logic [3:0]  memory_wstrb,
    input  logic [31:0] memory_rdata,
    input  logic        memory_ready
);

    mem_in_type  w_ireq;
    mem_in_type  w_dreq;
    mem_in_type  w_islot;
    mem_in_type  w_dslot;
    mem_out_type w_iresp;
    mem_out_type w_dresp;

    arb_state_t  r_state;
    arb_state_t  w_state_next;
    grant_t      r_last_grant;
    grant_t      w_last_grant_next;
    grant_t      w_pick;
    mem_in_type  r_mem;
    mem_in_type  w_mem_next;
    logic        w_iclear;
    logic        w_dclear;

    assign w_ireq = '{mem_valid: imemory_valid,
                      mem_instr: imemory_instr,
                      mem_addr:  imemory_addr,
                      mem_wdata: imemory_wdata,
                      mem_wstrb: imemory_wstrb};

    assign w_dreq = '{mem_valid: dmemory_valid,
                      mem_instr: dmemory_instr,
                      mem_addr:  dmemory_addr,
                      mem_wdata: dmemory_wdata,
                      mem_wstrb: dmemory_wstrb};

    mem_arbiter_slot u_islot (
        .clock   (clock),
        .reset   (reset),
        .i_req   (w_ireq),
        .i_clear (w_iclear),
        .o_req   (w_islot)
    );

    mem_arbiter_slot u_dslot (
        .clock   (clock),
        .reset   (reset),
        .i_req   (w_dreq),
        .i_clear (w_dclear),
        .o_req   (w_dslot)
    );

    assign w_pick = arb_pick(w_islot.mem_valid, w_dslot.mem_valid,
                             r_last_grant, round_robin != 0);

    always_comb begin
        w_state_next      = r_state;
        w_last_grant_next = r_last_grant;
        w_mem_next        = r_mem;
        w_mem_next.mem_valid = 1'b0;
        w_iclear          = 1'b0;
        w_dclear          = 1'b0;
        w_iresp           = '0;
        w_dresp           = '0;
        case (r_state)
            ARB_IDLE: begin
                if (w_islot.mem_valid || w_dslot.mem_valid) begin
                    w_mem_next           = (w_pick == GRANT_D) ? w_dslot : w_islot;
                    w_mem_next.mem_valid = 1'b1;
                    w_last_grant_next    = w_pick;
                    w_state_next         = (w_pick == GRANT_D) ? ARB_BUSY_D : ARB_BUSY_I;
                end
            end
            ARB_BUSY_I: begin
                if (memory_ready) begin
                    w_iresp.mem_ready = 1'b1;
                    w_iresp.mem_rdata = memory_rdata;
                    w_iclear          = 1'b1;
                    w_state_next      = ARB_IDLE;
                end
            end
            ARB_BUSY_D: begin
                if (memory_ready) begin
                    w_dresp.mem_ready = 1'b1;
                    w_dresp.mem_rdata = memory_rdata;
                    w_dclear          = 1'b1;
                    w_state_next      = ARB_IDLE;
                end
            end
            default: begin
                w_state_next = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= ARB_IDLE;
            r_last_grant <= GRANT_I;
            r_mem        <= '0;
        end else begin
            r_state      <= w_state_next;
            r_last_grant <= w_last_grant_next;
            r_mem        <= w_mem_next;
        end
    end

    // Bus fields stay at the last grant's values between requests.
    assign memory_valid  = r_mem.mem_valid;
    assign memory_instr  = r_mem.mem_instr;
    assign memory_addr   = r_mem.mem_addr;
    assign memory_wdata  = r_mem.mem_wdata;
    assign memory_wstrb  = r_mem.mem_wstrb;

    assign imemory_ready = w_iresp.mem_ready;
    assign imemory_rdata = w_iresp.mem_rdata;
    assign dmemory_ready = w_dresp.mem_ready;
    assign dmemory_rdata = w_dresp.mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a round-robin and a data-first instance, each checked
// every cycle against a transaction-level model of slots, grants and responses.
module tb_mem_arbiter;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    // index 0: round_robin=1, index 1: round_robin=0
    logic        iv[2], ii[2], dv[2], di[2], mv[2], mi[2], irdy[2], drdy[2], mrdy[2];
    logic [31:0] ia[2], iw[2], da[2], dw[2], ird[2], drd[2], ma[2], mw[2], mrd[2];
    logic [3:0]  is[2], ds[2], ms[2];

    mem_arbiter #(.round_robin(1)) u_rr (
        .reset(reset), .clock(clock),
        .imemory_valid(iv[0]), .imemory_instr(ii[0]), .imemory_addr(ia[0]),
        .imemory_wdata(iw[0]), .imemory_wstrb(is[0]), .imemory_rdata(ird[0]),
        .imemory_ready(irdy[0]),
        .dmemory_valid(dv[0]), .dmemory_instr(di[0]), .dmemory_addr(da[0]),
        .dmemory_wdata(dw[0]), .dmemory_wstrb(ds[0]), .dmemory_rdata(drd[0]),
        .dmemory_ready(drdy[0]),
        .memory_valid(mv[0]), .memory_instr(mi[0]), .memory_addr(ma[0]),
        .memory_wdata(mw[0]), .memory_wstrb(ms[0]), .memory_rdata(mrd[0]),
        .memory_ready(mrdy[0])
    );

    mem_arbiter #(.round_robin(0)) u_fp (
        .reset(reset), .clock(clock),
        .imemory_valid(iv[1]), .imemory_instr(ii[1]), .imemory_addr(ia[1]),
        .imemory_wdata(iw[1]), .imemory_wstrb(is[1]), .imemory_rdata(ird[1]),
        .imemory_ready(irdy[1]),
        .dmemory_valid(dv[1]), .dmemory_instr(di[1]), .dmemory_addr(da[1]),
        .dmemory_wdata(dw[1]), .dmemory_wstrb(ds[1]), .dmemory_rdata(drd[1]),
        .dmemory_ready(drdy[1]),
        .memory_valid(mv[1]), .memory_instr(mi[1]), .memory_addr(ma[1]),
        .memory_wdata(mw[1]), .memory_wstrb(ms[1]), .memory_rdata(mrd[1]),
        .memory_ready(mrdy[1])
    );

    // Reference model: per side a one-entry request buffer, one outstanding bus transaction.
    bit          m_pend[2][2];
    logic        m_instr[2][2];
    logic [31:0] m_addr[2][2];
    logic [31:0] m_wdata[2][2];
    logic [3:0]  m_wstrb[2][2];
    bit          m_busy[2];
    int          m_side[2];
    int          m_last[2];
    int          m_rcnt[2];
    logic        e_valid[2], e_instr[2];
    logic [31:0] e_addr[2], e_wdata[2];
    logic [3:0]  e_wstrb[2];

    int          fix_delay = -1;
    bit          spurious[2];
    int          n_cmp = 0;
    int          n_err = 0;
    int          gcnt[2];
    logic [31:0] glog[2][16];
    int          n_acc[2][2];
    int          n_obs[2][2];

    task automatic check_eq(input string tag, input int k,
                            input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s[dut%0d] got=0x%08h expected=0x%08h t=%0t", tag, k, got, exp, $time);
        end
    endtask

    function automatic int pick(input bit pi, input bit pd, input int last, input bit rr);
        if (pi && pd) return (rr && last == 1) ? 0 : 1;
        if (pd) return 1;
        if (pi) return 0;
        return -1;
    endfunction

    function automatic bit rdy_now(input int k);
        return m_busy[k] && (m_rcnt[k] == 0);
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 2; k++) begin
            for (int s = 0; s < 2; s++) m_pend[k][s] = 1'b0;
            m_busy[k] = 1'b0; m_side[k] = 0; m_last[k] = 0; m_rcnt[k] = 0;
            e_valid[k] = 1'b0; e_instr[k] = 1'b0; e_addr[k] = '0; e_wdata[k] = '0; e_wstrb[k] = '0;
        end
    endtask

    task automatic clear_inputs();
        for (int k = 0; k < 2; k++) begin
            iv[k] = 1'b0; dv[k] = 1'b0; spurious[k] = 1'b0;
        end
    endtask

    task automatic drive(input int k, input int s, input logic [31:0] a,
                         input logic [31:0] w, input logic [3:0] st, input logic ins);
        if (s == 0) begin
            iv[k] = 1'b1; ia[k] = a; iw[k] = w; is[k] = st; ii[k] = ins;
        end else begin
            dv[k] = 1'b1; da[k] = a; dw[k] = w; ds[k] = st; di[k] = ins;
        end
    endtask

    // One clock cycle: drive responder, check outputs at negedge, advance model after posedge.
    task automatic step();
        bit comp[2];
        int g;
        for (int k = 0; k < 2; k++) begin
            mrdy[k] = rdy_now(k) || (!m_busy[k] && spurious[k]);
            mrd[k]  = $urandom;
        end
        @(negedge clock);
        for (int k = 0; k < 2; k++) begin
            bit ei = m_busy[k] && m_side[k] == 0 && mrdy[k];
            bit ed = m_busy[k] && m_side[k] == 1 && mrdy[k];
            check_eq("memory_valid", k, mv[k], e_valid[k]);
            check_eq("memory_addr",  k, ma[k], e_addr[k]);
            check_eq("memory_wdata", k, mw[k], e_wdata[k]);
            check_eq("memory_wstrb", k, ms[k], e_wstrb[k]);
            check_eq("memory_instr", k, mi[k], e_instr[k]);
            check_eq("imem_ready",   k, irdy[k], ei);
            check_eq("imem_rdata",   k, ird[k], ei ? mrd[k] : 32'd0);
            check_eq("dmem_ready",   k, drdy[k], ed);
            check_eq("dmem_rdata",   k, drd[k], ed ? mrd[k] : 32'd0);
            if (mv[k] === 1'b1 && gcnt[k] < 16) begin
                glog[k][gcnt[k]] = ma[k];
                gcnt[k]++;
            end
            if (irdy[k] === 1'b1) n_obs[k][0]++;
            if (drdy[k] === 1'b1) n_obs[k][1]++;
        end
        @(posedge clock);
        #1;
        for (int k = 0; k < 2; k++) begin
            comp[0] = m_busy[k] && m_side[k] == 0 && mrdy[k];
            comp[1] = m_busy[k] && m_side[k] == 1 && mrdy[k];
            g = m_busy[k] ? -1 : pick(m_pend[k][0], m_pend[k][1], m_last[k], k == 0);
            if (comp[0] || comp[1]) m_busy[k] = 1'b0;
            else if (m_busy[k]) m_rcnt[k]--;
            if (g >= 0) begin
                e_valid[k] = 1'b1;
                e_instr[k] = m_instr[k][g]; e_addr[k] = m_addr[k][g];
                e_wdata[k] = m_wdata[k][g]; e_wstrb[k] = m_wstrb[k][g];
                m_last[k] = g; m_side[k] = g; m_busy[k] = 1'b1;
                m_rcnt[k] = (fix_delay >= 0) ? fix_delay : int'($urandom_range(0, 3));
            end else begin
                e_valid[k] = 1'b0;
            end
            for (int s = 0; s < 2; s++) begin
                logic v = (s == 0) ? iv[k] : dv[k];
                if (v && (!m_pend[k][s] || comp[s])) begin
                    m_pend[k][s]  = 1'b1;
                    m_instr[k][s] = (s == 0) ? ii[k] : di[k];
                    m_addr[k][s]  = (s == 0) ? ia[k] : da[k];
                    m_wdata[k][s] = (s == 0) ? iw[k] : dw[k];
                    m_wstrb[k][s] = (s == 0) ? is[k] : ds[k];
                    n_acc[k][s]++;
                end else if (comp[s]) begin
                    m_pend[k][s] = 1'b0;
                end
            end
        end
        clear_inputs();
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        for (int k = 0; k < 2; k++) mrdy[k] = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            check_eq("rst_mvalid", k, mv[k], 32'd0);
            check_eq("rst_maddr",  k, ma[k], 32'd0);
            check_eq("rst_mwdata", k, mw[k], 32'd0);
            check_eq("rst_mwstrb", k, ms[k], 32'd0);
            check_eq("rst_minstr", k, mi[k], 32'd0);
            check_eq("rst_irdy",   k, irdy[k], 32'd0);
            check_eq("rst_ird",    k, ird[k], 32'd0);
            check_eq("rst_drdy",   k, drdy[k], 32'd0);
            check_eq("rst_drd",    k, drd[k], 32'd0);
        end
        model_clear();
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
    endtask

    task automatic clear_log();
        for (int k = 0; k < 2; k++) gcnt[k] = 0;
    endtask

    initial begin
        bit reissued[2];
        for (int k = 0; k < 2; k++) begin
            ia[k] = '0; iw[k] = '0; is[k] = '0; ii[k] = 1'b0;
            da[k] = '0; dw[k] = '0; ds[k] = '0; di[k] = 1'b0;
            mrdy[k] = 1'b0; mrd[k] = '0;
            for (int s = 0; s < 2; s++) begin n_acc[k][s] = 0; n_obs[k][s] = 0; end
        end
        clear_inputs();
        clear_log();
        model_clear();
        do_reset();

        // Single I-side read, memory answers one cycle after the request pulse.
        fix_delay = 1;
        clear_log();
        for (int k = 0; k < 2; k++) drive(k, 0, 32'h100, 32'h0, 4'h0, 1'b1);
        step();
        idle(6);
        for (int k = 0; k < 2; k++) begin
            check_eq("single_cnt",  k, gcnt[k], 32'd1);
            check_eq("single_addr", k, glog[k][0], 32'h100);
        end
        $display("txn single_read: done");

        // Tie after reset, then D re-requests in its completion cycle to form a second tie.
        fix_delay = 2;
        clear_log();
        reissued[0] = 1'b0; reissued[1] = 1'b0;
        for (int k = 0; k < 2; k++) begin
            drive(k, 0, 32'h200, 32'h0, 4'h0, 1'b1);
            drive(k, 1, 32'h8000, 32'h1234_5678, 4'hF, 1'b0);
        end
        step();
        for (int c = 0; c < 20; c++) begin
            for (int k = 0; k < 2; k++) begin
                if (!reissued[k] && rdy_now(k) && m_side[k] == 1) begin
                    drive(k, 1, 32'h9000, 32'hCAFE_0001, 4'h3, 1'b0);
                    reissued[k] = 1'b1;
                end
            end
            step();
        end
        check_eq("tie_cnt",  0, gcnt[0], 32'd3);
        check_eq("tie_g0",   0, glog[0][0], 32'h8000);
        check_eq("tie_g1",   0, glog[0][1], 32'h200);
        check_eq("tie_g2",   0, glog[0][2], 32'h9000);
        check_eq("fixp_cnt", 1, gcnt[1], 32'd3);
        check_eq("fixp_g0",  1, glog[1][0], 32'h8000);
        check_eq("fixp_g1",  1, glog[1][1], 32'h9000);
        check_eq("fixp_g2",  1, glog[1][2], 32'h200);
        $display("txn tie_and_priority: done");

        // Back-to-back D: new request in the completion cycle is queued, not dropped.
        fix_delay = 0;
        clear_log();
        reissued[0] = 1'b0; reissued[1] = 1'b0;
        for (int k = 0; k < 2; k++) drive(k, 1, 32'hA000, 32'h0, 4'h0, 1'b0);
        step();
        for (int c = 0; c < 10; c++) begin
            for (int k = 0; k < 2; k++) begin
                if (!reissued[k] && rdy_now(k)) begin
                    drive(k, 1, 32'hA004, 32'h0, 4'h0, 1'b0);
                    reissued[k] = 1'b1;
                end
            end
            step();
        end
        for (int k = 0; k < 2; k++) begin
            check_eq("b2b_cnt", k, gcnt[k], 32'd2);
            check_eq("b2b_g1",  k, glog[k][1], 32'hA004);
        end
        $display("txn back_to_back: done");

        // memory_ready while idle must not reach either port (checked inside step).
        for (int k = 0; k < 2; k++) spurious[k] = 1'b1;
        step();
        $display("txn ready_in_idle: done");

        // Duplicate I pulse while pending is dropped.
        fix_delay = 3;
        clear_log();
        for (int k = 0; k < 2; k++) drive(k, 0, 32'hB000, 32'h0, 4'h0, 1'b1);
        step();
        for (int k = 0; k < 2; k++) drive(k, 0, 32'hB004, 32'h0, 4'h0, 1'b1);
        step();
        idle(8);
        for (int k = 0; k < 2; k++) begin
            check_eq("dup_cnt",  k, gcnt[k], 32'd1);
            check_eq("dup_addr", k, glog[k][0], 32'hB000);
        end
        $display("txn duplicate_drop: done");

        // Reset while BUSY_D, late ready ignored, then a normal request.
        fix_delay = 3;
        for (int k = 0; k < 2; k++) drive(k, 1, 32'hC000, 32'h5555_AAAA, 4'h3, 1'b0);
        idle(3);
        for (int k = 0; k < 2; k++) check_eq("busy_before_rst", k, mv[k] | m_busy[k], 32'd1);
        do_reset();
        for (int k = 0; k < 2; k++) spurious[k] = 1'b1;
        step();
        fix_delay = 1;
        clear_log();
        for (int k = 0; k < 2; k++) drive(k, 0, 32'hC100, 32'h0, 4'h0, 1'b1);
        step();
        idle(6);
        for (int k = 0; k < 2; k++) begin
            check_eq("post_rst_cnt",  k, gcnt[k], 32'd1);
            check_eq("post_rst_addr", k, glog[k][0], 32'hC100);
        end
        $display("txn reset_mid_transaction: done");

        // Randomized traffic on both instances, including occasional dropped duplicates.
        fix_delay = -1;
        for (int k = 0; k < 2; k++) for (int s = 0; s < 2; s++) begin
            n_acc[k][s] = 0; n_obs[k][s] = 0;
        end
        for (int c = 0; c < 3000; c++) begin
            for (int k = 0; k < 2; k++) begin
                for (int s = 0; s < 2; s++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        if (!m_pend[k][s] || (rdy_now(k) && m_side[k] == s) ||
                            $urandom_range(0, 5) == 0)
                            drive(k, s, $urandom, $urandom, 4'($urandom_range(0, 15)),
                                  1'($urandom_range(0, 1)));
                    end
                end
                if (!m_busy[k] && $urandom_range(0, 7) == 0) spurious[k] = 1'b1;
            end
            step();
        end
        idle(12);
        for (int k = 0; k < 2; k++) begin
            check_eq("rand_done_i", k, n_obs[k][0], n_acc[k][0]);
            check_eq("rand_done_d", k, n_obs[k][1], n_acc[k][1]);
        end
        $display("txn random_traffic: done");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
